// File: rtl/ccff_pkg.sv
// Shared types and constants for the configuration-chain tail receiver.
package ccff_pkg;

  typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH, DONE} rx_state_e;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // One serial step of CRC-16-CCITT, MSB first, no reflection.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return fb ? ({crc[14:0], 1'b0} ^ CRC16_POLY) : {crc[14:0], 1'b0};
  endfunction

endpackage

// File: rtl/ccff_rx_fifo.sv
// First-word-fall-through synchronous FIFO with a synchronous clear.
module ccff_rx_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // A push into a full FIFO is accepted only when the head leaves on the same edge.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push && (!full || (pop && !empty))) begin
        mem_d[wr_ptr_q[AW-1:0]] = push_data;
        wr_ptr_d                = wr_ptr_q + 1'b1;
      end
      if (pop && !empty) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/ccff_tail_rx.sv
// Packs bits leaving the configuration chain tail into words and queues them for readback.
// Optional running CRC-16-CCITT over sampled bits when CCFF_TAIL_RX_CRC_EN is defined.
module ccff_tail_rx
  import ccff_pkg::*;
#(
  parameter int CHAIN_LEN  = 1024,
  parameter int WORD_W     = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              shift_en,
  input  logic              ccff_tail,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              word_last,
  output logic [CNT_W-1:0]  bit_count,
  output logic              done,
  output logic              overflow,
  output logic [15:0]       crc_out
);

  localparam int WB_W = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHAIN_LEN - 1);
  localparam logic [WB_W-1:0]  WORD_END = WB_W'(WORD_W - 1);

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  bit_count_q, bit_count_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [WB_W-1:0]   wbits_q, wbits_d;
  logic              done_q, done_d;
  logic              overflow_q, overflow_d;

  logic              push, push_last, pop;
  logic [WORD_W-1:0] push_data, flush_word;
  logic              fifo_full, fifo_empty;

`ifdef CCFF_TAIL_RX_CRC_EN
  logic [15:0] crc_q, crc_d;
  assign crc_out = crc_q;
`else
  assign crc_out = 16'h0000;
`endif

  assign pop        = word_ready && !fifo_empty;
  assign word_valid = !fifo_empty;
  assign bit_count  = bit_count_q;
  assign done       = done_q;
  assign overflow   = overflow_q;
  assign flush_word = shift_q << (WORD_W - int'(wbits_q));

  always_comb begin
    state_d     = state_q;
    bit_count_d = bit_count_q;
    shift_d     = shift_q;
    wbits_d     = wbits_q;
    done_d      = done_q;
    overflow_d  = overflow_q;
    push        = 1'b0;
    push_last   = 1'b0;
    push_data   = '0;
`ifdef CCFF_TAIL_RX_CRC_EN
    crc_d       = crc_q;
`endif
    if (start) begin
      state_d     = CAPTURE;
      bit_count_d = '0;
      shift_d     = '0;
      wbits_d     = '0;
      done_d      = 1'b0;
      overflow_d  = 1'b0;
`ifdef CCFF_TAIL_RX_CRC_EN
      crc_d       = CRC16_INIT;
`endif
    end else begin
      case (state_q)
        CAPTURE: begin
          if (shift_en) begin
            bit_count_d = bit_count_q + 1'b1;
`ifdef CCFF_TAIL_RX_CRC_EN
            crc_d       = crc16_step(crc_q, ccff_tail);
`endif
            if (wbits_q == WORD_END) begin
              push      = 1'b1;
              push_data = {shift_q[WORD_W-2:0], ccff_tail};
              push_last = (bit_count_q == LAST_IDX);
              shift_d   = '0;
              wbits_d   = '0;
              if (fifo_full && !pop) begin
                overflow_d = 1'b1;
              end
            end else begin
              shift_d = {shift_q[WORD_W-2:0], ccff_tail};
              wbits_d = wbits_q + 1'b1;
            end
            // The last chain bit decides whether a partial word still needs flushing.
            if (bit_count_q == LAST_IDX) begin
              if (wbits_q == WORD_END) begin
                state_d = DONE;
                done_d  = 1'b1;
              end else begin
                state_d = FLUSH;
              end
            end
          end
        end
        FLUSH: begin
          if (!fifo_full || pop) begin
            push      = 1'b1;
            push_data = flush_word;
            push_last = 1'b1;
            state_d   = DONE;
            done_d    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_count_q <= '0;
      shift_q     <= '0;
      wbits_q     <= '0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
`ifdef CCFF_TAIL_RX_CRC_EN
      crc_q       <= CRC16_INIT;
`endif
    end else begin
      state_q     <= state_d;
      bit_count_q <= bit_count_d;
      shift_q     <= shift_d;
      wbits_q     <= wbits_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
`ifdef CCFF_TAIL_RX_CRC_EN
      crc_q       <= crc_d;
`endif
    end
  end

  ccff_rx_fifo #(
    .WIDTH (WORD_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (start),
    .push      (push),
    .push_data ({push_last, push_data}),
    .pop       (pop),
    .head_data ({word_last, word_data}),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_ccff_tail_rx.sv
// Directed bench for ccff_tail_rx: three instances (16, 12 and 48 bit chains) share one stimulus stream.
module tb_ccff_tail_rx;

  logic clk = 1'b0;
  logic rst_n, start, shift_en, ccff_tail, word_ready;

  logic [7:0]  d16, d12, d48;
  logic        v16, v12, v48, l16, l12, l48;
  logic        dn16, dn12, dn48, ov16, ov12, ov48;
  logic [4:0]  c16;
  logic [3:0]  c12;
  logic [5:0]  c48;
  logic [15:0] crc16o, crc12o, crc48o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ccff_tail_rx #(.CHAIN_LEN(16), .WORD_W(8), .FIFO_DEPTH(4)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start), .shift_en(shift_en), .ccff_tail(ccff_tail),
    .word_data(d16), .word_valid(v16), .word_ready(word_ready), .word_last(l16),
    .bit_count(c16), .done(dn16), .overflow(ov16), .crc_out(crc16o));

  ccff_tail_rx #(.CHAIN_LEN(12), .WORD_W(8), .FIFO_DEPTH(4)) u12 (
    .clk(clk), .rst_n(rst_n), .start(start), .shift_en(shift_en), .ccff_tail(ccff_tail),
    .word_data(d12), .word_valid(v12), .word_ready(word_ready), .word_last(l12),
    .bit_count(c12), .done(dn12), .overflow(ov12), .crc_out(crc12o));

  ccff_tail_rx #(.CHAIN_LEN(48), .WORD_W(8), .FIFO_DEPTH(4)) u48 (
    .clk(clk), .rst_n(rst_n), .start(start), .shift_en(shift_en), .ccff_tail(ccff_tail),
    .word_data(d48), .word_valid(v48), .word_ready(word_ready), .word_last(l48),
    .bit_count(c48), .done(dn48), .overflow(ov48), .crc_out(crc48o));

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic applyStimulus(input logic s, input logic se, input logic b);
    start     = s;
    shift_en  = se;
    ccff_tail = b;
    @(posedge clk);
    #1;
  endtask

  task automatic shiftByte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      applyStimulus(1'b0, 1'b1, v[i]);
    end
  endtask

  function automatic logic [15:0] crcModel(input logic [15:0] init, input logic [7:0] data);
    logic [15:0] c;
    c = init ^ {data, 8'h00};
    for (int k = 0; k < 8; k++) begin
      c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  logic [7:0] drain_exp [4];
  logic [7:0] pat;

  initial begin
    drain_exp[0] = 8'h11; drain_exp[1] = 8'h22; drain_exp[2] = 8'h33; drain_exp[3] = 8'h44;
    rst_n = 1'b0; start = 1'b0; shift_en = 1'b0; ccff_tail = 1'b0; word_ready = 1'b1;
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("reset_valid", v16, 1'b0);
    checkOutput("reset_data", d16, 8'h00);
    checkOutput("reset_last", l16, 1'b0);
    checkOutput("reset_count", c16, 5'd0);
    checkOutput("reset_done", dn16, 1'b0);
    checkOutput("reset_ovf", ov16, 1'b0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("idle_ignores_shift", c16, 5'd0);

    // Case 1: 16-bit chain, two full words.
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("c1_start_count", c16, 5'd0);
    shiftByte(8'hA5);
    checkOutput("c1_w0_valid", v16, 1'b1);
    checkOutput("c1_w0_data", d16, 8'hA5);
    checkOutput("c1_w0_last", l16, 1'b0);
    checkOutput("c1_w0_done", dn16, 1'b0);
    shiftByte(8'hF0);
    checkOutput("c1_w1_data", d16, 8'hF0);
    checkOutput("c1_w1_last", l16, 1'b1);
    checkOutput("c1_done", dn16, 1'b1);
    checkOutput("c1_count", c16, 5'd16);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("c1_drained", v16, 1'b0);
    checkOutput("c1_done_ignores_shift", c16, 5'd16);

    // Case 2: 12-bit chain, trailing half word flushed left-aligned.
    applyStimulus(1'b1, 1'b0, 1'b0);
    shiftByte(8'hCC);
    checkOutput("c2_w0_data", d12, 8'hCC);
    checkOutput("c2_w0_last", l12, 1'b0);
    pat = 8'hA0;
    for (int i = 7; i >= 4; i--) applyStimulus(1'b0, 1'b1, pat[i]);
    checkOutput("c2_count", c12, 4'd12);
    checkOutput("c2_done_during_flush", dn12, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("c2_flush_valid", v12, 1'b1);
    checkOutput("c2_flush_data", d12, 8'hA0);
    checkOutput("c2_flush_last", l12, 1'b1);
    checkOutput("c2_done", dn12, 1'b1);
    checkOutput("c2_count_sat", c12, 4'd12);

    // Case 3: consumer stalled, six words into a four-deep FIFO.
    word_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int w = 1; w <= 6; w++) shiftByte(8'(w * 8'h11));
    checkOutput("c3_overflow", ov48, 1'b1);
    checkOutput("c3_done", dn48, 1'b1);
    checkOutput("c3_count", c48, 6'd48);
    checkOutput("c3_valid", v48, 1'b1);
    word_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("c3_drain%0d_data", i), d48, drain_exp[i]);
      checkOutput($sformatf("c3_drain%0d_last", i), l48, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
    checkOutput("c3_empty", v48, 1'b0);

    // Case 4: start again mid-capture clears everything.
    word_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("c4_ovf_clr", ov48, 1'b0);
    checkOutput("c4_done_clr", dn48, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("c4_count5", c16, 5'd5);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("c4_restart_count", c16, 5'd0);
    checkOutput("c4_restart_valid", v16, 1'b0);
    word_ready = 1'b1;

    // Case 5: shift_en alternating; the gap cycles drive inverted bits that must be ignored.
    pat = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      applyStimulus(1'b0, 1'b1, pat[i]);
      if (i != 0) applyStimulus(1'b0, 1'b0, ~pat[i]);
    end
    checkOutput("c5_w0_data", d16, 8'hA5);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("c5_gap_count", c16, 5'd8);
    pat = 8'hF0;
    for (int i = 7; i >= 0; i--) begin
      applyStimulus(1'b0, 1'b1, pat[i]);
      if (i != 0) applyStimulus(1'b0, 1'b0, ~pat[i]);
    end
    checkOutput("c5_w1_data", d16, 8'hF0);
    checkOutput("c5_w1_last", l16, 1'b1);
    checkOutput("c5_done", dn16, 1'b1);
`ifdef CCFF_TAIL_RX_CRC_EN
    checkOutput("c5_crc", crc16o, crcModel(crcModel(16'hFFFF, 8'hA5), 8'hF0));
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("c5_crc_hold", crc16o, crcModel(crcModel(16'hFFFF, 8'hA5), 8'hF0));
`endif

    // Case 6: CRC over one byte 0x31.
    applyStimulus(1'b1, 1'b0, 1'b0);
    shiftByte(8'h31);
`ifdef CCFF_TAIL_RX_CRC_EN
    checkOutput("c6_crc", crc48o, crcModel(16'hFFFF, 8'h31));
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("c6_crc_noshift", crc48o, crcModel(16'hFFFF, 8'h31));
`else
    checkOutput("c6_crc_off", crc48o, 16'h0000);
`endif

    // Reset in the middle of a capture returns to the reset state.
    applyStimulus(1'b0, 1'b1, 1'b1);
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("rst_mid_count", c48, 6'd0);
    checkOutput("rst_mid_valid", v48, 1'b0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("rst_mid_idle", c48, 6'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
